// File: rtl/uart_rx_frame_checker_if.sv
// Bus between the RX bit sampler/config registers and the frame checker.
// The master drives bit strobes and config; the slave returns frame results and counters.
interface uart_rx_frame_checker_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
);
  logic                  frame_start;
  logic                  bit_valid;
  logic                  sampled_bit;
  logic                  par_en;
  logic [1:0]            par_mode;
  logic                  stop2;
  logic                  err_clr;
  logic                  busy;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;
  logic [CNT_WIDTH-1:0]  par_err_cnt;
  logic [CNT_WIDTH-1:0]  stp_err_cnt;

  modport master (
    output frame_start, bit_valid, sampled_bit, par_en, par_mode, stop2, err_clr,
    input  busy, p_data, data_valid, par_err, stp_err, par_err_cnt, stp_err_cnt
  );

  modport slave (
    input  frame_start, bit_valid, sampled_bit, par_en, par_mode, stop2, err_clr,
    output busy, p_data, data_valid, par_err, stp_err, par_err_cnt, stp_err_cnt
  );
endinterface

// File: rtl/uart_rx_frame_checker.sv
// UART RX frame deserialiser with serial parity check (even/odd/mark/space),
// one or two stop bits, per-frame error flags and saturating error counters.
module uart_rx_frame_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  uart_rx_frame_checker_if.slave bus
);

  typedef enum logic [2:0] {IDLE, DATA, PAR, STOP, DONE} state_t;

  localparam logic [3:0]           LAST_DATA = 4'(DATA_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

  function automatic logic expected_parity(input logic [1:0] mode, input logic acc);
    case (mode)
      2'b00:   return acc;
      2'b01:   return ~acc;
      2'b10:   return 1'b1;
      2'b11:   return 1'b0;
      default: return 1'b0;
    endcase
  endfunction

  // Clear has priority over the saturating increment.
  function automatic logic [CNT_WIDTH-1:0] next_cnt(input logic [CNT_WIDTH-1:0] cnt,
                                                    input logic inc, input logic clr);
    if (clr) begin
      return {CNT_WIDTH{1'b0}};
    end else if (inc && (cnt != CNT_MAX)) begin
      return cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      return cnt;
    end
  endfunction

  state_t                state_q, state_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  acc_q, acc_d;
  logic                  par_en_q, par_en_d;
  logic [1:0]            par_mode_q, par_mode_d;
  logic                  stop2_q, stop2_d;
  logic                  par_flag_q, par_flag_d;
  logic                  stp_flag_q, stp_flag_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic [CNT_WIDTH-1:0]  par_cnt_q, par_cnt_d;
  logic [CNT_WIDTH-1:0]  stp_cnt_q, stp_cnt_d;
  logic                  done_d;

  // Next-state and next-output logic; frame_start overrides every state.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    acc_d        = acc_q;
    par_en_d     = par_en_q;
    par_mode_d   = par_mode_q;
    stop2_d      = stop2_q;
    par_flag_d   = par_flag_q;
    stp_flag_d   = stp_flag_q;
    p_data_d     = p_data_q;
    par_err_d    = par_err_q;
    stp_err_d    = stp_err_q;
    data_valid_d = 1'b0;
    done_d       = 1'b0;

    if (bus.frame_start) begin
      state_d    = DATA;
      bit_cnt_d  = 4'd0;
      acc_d      = 1'b0;
      par_flag_d = 1'b0;
      stp_flag_d = 1'b0;
      par_err_d  = 1'b0;
      stp_err_d  = 1'b0;
      par_en_d   = bus.par_en;
      par_mode_d = bus.par_mode;
      stop2_d    = bus.stop2;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        DATA: begin
          if (bus.bit_valid) begin
            shift_d = {bus.sampled_bit, shift_q[DATA_WIDTH-1:1]};
            acc_d   = acc_q ^ bus.sampled_bit;
            if (bit_cnt_q == LAST_DATA) begin
              bit_cnt_d = 4'd0;
              state_d   = par_en_q ? PAR : STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else begin
            state_d = DATA;
          end
        end
        PAR: begin
          if (bus.bit_valid) begin
            par_flag_d = (bus.sampled_bit != expected_parity(par_mode_q, acc_q));
            state_d    = STOP;
          end else begin
            state_d = PAR;
          end
        end
        STOP: begin
          if (bus.bit_valid) begin
            stp_flag_d = stp_flag_q | ~bus.sampled_bit;
            if (!stop2_q || (bit_cnt_q == 4'd1)) begin
              state_d = DONE;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else begin
            state_d = STOP;
          end
        end
        DONE: begin
          done_d       = 1'b1;
          data_valid_d = 1'b1;
          p_data_d     = shift_q;
          par_err_d    = par_flag_q;
          stp_err_d    = stp_flag_q;
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    par_cnt_d = next_cnt(par_cnt_q, done_d & par_flag_q, bus.err_clr);
    stp_cnt_d = next_cnt(stp_cnt_q, done_d & stp_flag_q, bus.err_clr);
    busy_d    = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= 4'd0;
      shift_q      <= {DATA_WIDTH{1'b0}};
      acc_q        <= 1'b0;
      par_en_q     <= 1'b0;
      par_mode_q   <= 2'b00;
      stop2_q      <= 1'b0;
      par_flag_q   <= 1'b0;
      stp_flag_q   <= 1'b0;
      busy_q       <= 1'b0;
      p_data_q     <= {DATA_WIDTH{1'b0}};
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      par_cnt_q    <= {CNT_WIDTH{1'b0}};
      stp_cnt_q    <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      acc_q        <= acc_d;
      par_en_q     <= par_en_d;
      par_mode_q   <= par_mode_d;
      stop2_q      <= stop2_d;
      par_flag_q   <= par_flag_d;
      stp_flag_q   <= stp_flag_d;
      busy_q       <= busy_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
      par_cnt_q    <= par_cnt_d;
      stp_cnt_q    <= stp_cnt_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.p_data      = p_data_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.par_err     = par_err_q;
  assign bus.stp_err     = stp_err_q;
  assign bus.par_err_cnt = par_cnt_q;
  assign bus.stp_err_cnt = stp_cnt_q;

endmodule
